// File: rtl/icache_param.sv
// Direct-mapped instruction cache with TLB lookup, uncacheable (PCD) bypass,
// whole-cache flush and a multi-beat line fill over a daisy-chained shared bus.
module icache_param #(
    parameter int ADDRW    = 32,
    parameter int LINEW    = 128,
    parameter int BUSDATAW = 32,
    parameter int NSETS    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDRW-1:0]    req_address,
    output logic                dp_valid,
    input  logic                dp_ready,
    output logic [LINEW-1:0]    dp_read_data,
    input  logic                flush,
    output logic [ADDRW-1:0]    virt_addr,
    input  logic [ADDRW-1:0]    phys_addr,
    input  logic                tlb_hit,
    input  logic                tlb_pcd,
    output logic                page_fault,
    output logic [ADDRW-1:0]    mem_addr,
    output logic                mem_rd_wr,
    output logic                mem_req,
    output logic                mem_en,
    input  logic                mem_data_valid,
    input  logic [BUSDATAW-1:0] mem_data,
    input  logic                grant_in,
    output logic                grant_out,
    input  logic                bus_busy_in,
    output logic                bus_busy_out
);

    localparam int BEATS = LINEW / BUSDATAW;
    localparam int IDXW  = $clog2(NSETS);
    localparam int OFFW  = $clog2(LINEW / 8);
    localparam int TAGW  = ADDRW - IDXW - OFFW;
    localparam int BEATW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BOFF  = $clog2(BUSDATAW / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_GRANT,
        S_FILL,
        S_RESP,
        S_FAULT
    } state_t;

    state_t             r_state;
    logic [ADDRW-1:0]   r_virt_addr;
    logic [ADDRW-1:0]   r_line_addr;
    logic               r_pcd;
    logic [BEATW-1:0]   r_beat;
    logic [LINEW-1:0]   r_acc;
    logic [LINEW-1:0]   r_dout;
    logic               r_flush_pend;
    logic [NSETS-1:0]   r_valid;
    logic [TAGW-1:0]    r_rd_tag;
    logic [LINEW-1:0]   r_rd_data;
    logic [TAGW-1:0]    r_tag_mem  [NSETS];
    logic [LINEW-1:0]   r_data_mem [NSETS];

    logic               w_flush_now;
    logic               w_accept;
    logic [IDXW-1:0]    w_idx;
    logic [IDXW-1:0]    w_req_idx;
    logic               w_hit;
    logic               w_last_beat;
    logic               w_fill_write;
    logic [LINEW-1:0]   w_fill_line;
    logic [ADDRW-1:0]   w_beat_addr;
    logic               w_unused_phys_low;

    // A flush seen in IDLE is applied at once; elsewhere it waits as pending.
    assign w_flush_now  = flush | r_flush_pend;
    assign req_ready    = (r_state == S_IDLE) & ~w_flush_now & ~reset;
    assign w_accept     = req_valid & req_ready;
    assign w_idx        = r_virt_addr[OFFW +: IDXW];
    assign w_req_idx    = req_address[OFFW +: IDXW];
    assign w_hit        = ~tlb_pcd & r_valid[w_idx] & (r_rd_tag == phys_addr[ADDRW-1 -: TAGW]);
    assign w_last_beat  = (r_state == S_FILL) & mem_data_valid & (r_beat == BEATW'(BEATS - 1));
    assign w_fill_write = w_last_beat & ~r_pcd;
    assign w_beat_addr  = r_line_addr + (ADDRW'(r_beat) << BOFF);
    assign w_unused_phys_low = ^phys_addr[OFFW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            assign w_fill_line[gi*BUSDATAW +: BUSDATAW] =
                (r_beat == BEATW'(gi)) ? mem_data : r_acc[gi*BUSDATAW +: BUSDATAW];
        end
    endgenerate

    assign virt_addr    = r_virt_addr;
    assign dp_read_data = r_dout;
    assign dp_valid     = (r_state == S_RESP);
    assign page_fault   = (r_state == S_FAULT);
    assign mem_req      = (r_state == S_WAIT_GRANT);
    assign bus_busy_out = (r_state == S_FILL);
    assign mem_en       = bus_busy_out;
    assign grant_out    = grant_in & ~mem_req & ~bus_busy_out;
    assign mem_addr     = bus_busy_out ? w_beat_addr : {ADDRW{1'bz}};
    assign mem_rd_wr    = bus_busy_out ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_virt_addr  <= '0;
            r_line_addr  <= '0;
            r_pcd        <= 1'b0;
            r_beat       <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
        end else begin
            if (flush && r_state != S_IDLE) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_flush_now) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (w_accept) begin
                        r_virt_addr <= req_address;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!tlb_hit) begin
                        r_state <= S_FAULT;
                    end else if (w_hit) begin
                        r_dout  <= r_rd_data;
                        r_state <= S_RESP;
                    end else begin
                        r_line_addr <= {phys_addr[ADDRW-1:OFFW], {OFFW{1'b0}}};
                        r_pcd       <= tlb_pcd;
                        r_state     <= S_WAIT_GRANT;
                    end
                end
                S_WAIT_GRANT: begin
                    if (grant_in && !bus_busy_in) begin
                        r_beat  <= '0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_data_valid) begin
                        r_acc <= w_fill_line;
                        if (w_last_beat) begin
                            r_dout  <= w_fill_line;
                            r_state <= S_RESP;
                            if (!r_pcd) begin
                                r_valid[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + BEATW'(1);
                        end
                    end
                end
                S_RESP: begin
                    if (dp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag/data arrays: read at accept so the stored line is ready during LOOKUP.
    always_ff @(posedge clk) begin
        if (w_fill_write) begin
            r_tag_mem[w_idx]  <= r_line_addr[ADDRW-1 -: TAGW];
            r_data_mem[w_idx] <= w_fill_line;
        end
        if (w_accept) begin
            r_rd_tag  <= r_tag_mem[w_req_idx];
            r_rd_data <= r_data_mem[w_req_idx];
        end
    end

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: table of fetch transactions with a bus
// responder and TLB stub, plus hand sequences for reset and IDLE flush.
module tb_icache_param;

    localparam logic [1:0] K_HIT   = 2'd0;
    localparam logic [1:0] K_MISS  = 2'd1;
    localparam logic [1:0] K_FAULT = 2'd2;
    localparam logic [1:0] K_RST   = 2'd3;
    localparam int NTV = 16;

    typedef struct packed {
        logic [31:0]  virt;
        logic [31:0]  phys;
        logic         th;
        logic         pcd;
        logic [1:0]   kind;
        logic [31:0]  b0;
        logic [127:0] line;
        logic         gap;
        logic [3:0]   hold;
        logic [2:0]   flush_beat;
        logic [2:0]   rst_beat;
    } tv_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_address;
    logic         dp_valid;
    logic         dp_ready;
    logic [127:0] dp_read_data;
    logic         flush;
    logic [31:0]  virt_addr;
    logic [31:0]  phys_addr;
    logic         tlb_hit;
    logic         tlb_pcd;
    logic         page_fault;
    wire  [31:0]  mem_addr;
    wire          mem_rd_wr;
    logic         mem_req;
    logic         mem_en;
    logic         mem_data_valid;
    logic [31:0]  mem_data;
    logic         grant_in;
    logic         grant_out;
    logic         bus_busy_in;
    logic         bus_busy_out;

    int checks = 0;
    int errors = 0;
    int cur_txn = -1;
    tv_t tv [NTV];

    icache_param #(.ADDRW(32), .LINEW(128), .BUSDATAW(32), .NSETS(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_read_data(dp_read_data),
        .flush(flush),
        .virt_addr(virt_addr), .phys_addr(phys_addr), .tlb_hit(tlb_hit), .tlb_pcd(tlb_pcd),
        .page_fault(page_fault),
        .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr), .mem_req(mem_req), .mem_en(mem_en),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .grant_in(grant_in), .grant_out(grant_out),
        .bus_busy_in(bus_busy_in), .bus_busy_out(bus_busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL txn%0d %s: got %h expected %h", cur_txn, name, act, exp);
        end
    endtask

    function automatic tv_t mk(input logic [31:0] v, input logic [31:0] p, input logic th,
                               input logic pcd, input logic [1:0] kind, input logic [31:0] b0,
                               input logic [127:0] line, input logic gap, input logic [3:0] hold,
                               input logic [2:0] fb, input logic [2:0] rb);
        tv_t t;
        t.virt = v; t.phys = p; t.th = th; t.pcd = pcd; t.kind = kind; t.b0 = b0;
        t.line = line; t.gap = gap; t.hold = hold; t.flush_beat = fb; t.rst_beat = rb;
        return t;
    endfunction

    task automatic do_txn(input int n, input tv_t t);
        int cyc, beats, last_cyc, first_dv, first_busy, faults;
        bit saw_req, grant_leak, en_bad, flush_done, done;
        logic [31:0] exp_addr;
        cur_txn = n;
        beats = 0; last_cyc = 0; first_dv = 0; first_busy = 0; faults = 0;
        saw_req = 0; grant_leak = 0; en_bad = 0; flush_done = 0; done = 0;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_before", req_ready, 1'b1);
        phys_addr   = t.phys;
        tlb_hit     = t.th;
        tlb_pcd     = t.pcd;
        req_valid   = 1'b1;
        req_address = t.virt;
        @(negedge clk);
        req_valid   = 1'b0;
        req_address = 32'hDEAD_BEEF;
        cyc = 1;
        while (!done && cyc < 300) begin
            bus_busy_in = (t.hold != 0) && (cyc <= 1 + int'(t.hold));
            if (cyc == 1) chk("virt_addr", virt_addr, t.virt);
            if (mem_req) saw_req = 1;
            if (mem_req && grant_out) grant_leak = 1;
            if (mem_en != bus_busy_out) en_bad = 1;
            if (page_fault) faults++;
            if (bus_busy_out && first_busy == 0) first_busy = cyc;
            flush = 1'b0;
            mem_data_valid = 1'b0;
            if (t.kind == K_RST && bus_busy_out && beats == int'(t.rst_beat)) begin
                reset = 1'b1;
                #1;
                chk("rst_bus_busy_out", bus_busy_out, 1'b0);
                chk("rst_mem_req", mem_req, 1'b0);
                chk("rst_dp_valid", dp_valid, 1'b0);
                chk("rst_mem_en", mem_en, 1'b0);
                chk("rst_dp_read_data", dp_read_data, 128'h0);
                chk("rst_req_ready", req_ready, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                done = 1;
            end else if (dp_valid) begin
                first_dv = cyc;
                chk("dp_read_data", dp_read_data, t.line);
                repeat (2) @(negedge clk);
                chk("dp_valid_held", dp_valid, 1'b1);
                chk("dp_read_data_held", dp_read_data, t.line);
                dp_ready = 1'b1;
                @(negedge clk);
                dp_ready = 1'b0;
                chk("dp_valid_after_ready", dp_valid, 1'b0);
                chk("req_ready_after", req_ready, t.flush_beat == 0);
                done = 1;
            end else if (t.kind == K_FAULT && cyc >= 6) begin
                done = 1;
            end else begin
                if (t.kind == K_FAULT && cyc == 3) chk("fault_req_ready", req_ready, 1'b1);
                if (t.flush_beat != 0 && !flush_done && bus_busy_out && beats == int'(t.flush_beat)) begin
                    flush = 1'b1;
                    flush_done = 1;
                end
                if (bus_busy_out && !(t.gap && (cyc % 2 == 1))) begin
                    exp_addr = {t.phys[31:4], 4'h0} + 32'(beats * 4);
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_rd_wr", mem_rd_wr, 1'b0);
                    mem_data_valid = 1'b1;
                    mem_data = 32'(t.b0 * (beats + 1));
                    beats++;
                    last_cyc = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        flush = 1'b0;
        mem_data_valid = 1'b0;
        bus_busy_in = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn%0d timeout: got no completion expected completion within 300 cycles", n);
        end
        chk("grant_out_while_req", grant_leak, 1'b0);
        chk("mem_en_eq_busy", en_bad, 1'b0);
        case (t.kind)
            K_HIT: begin
                chk("hit_latency", first_dv, 2);
                chk("hit_mem_req", saw_req, 1'b0);
                chk("hit_beats", beats, 0);
            end
            K_MISS: begin
                chk("miss_mem_req", saw_req, 1'b1);
                chk("miss_beats", beats, 4);
                chk("miss_busy_start", first_busy, 3 + int'(t.hold));
                chk("miss_dv_latency", first_dv, last_cyc + 1);
            end
            K_FAULT: begin
                chk("fault_pulses", faults, 1);
                chk("fault_mem_req", saw_req, 1'b0);
                chk("fault_dp_valid", first_dv, 0);
            end
            default: begin
                chk("rst_beats", beats, int'(t.rst_beat));
            end
        endcase
        $display("txn %0d virt=%h phys=%h kind=%0d beats=%0d dv_cyc=%0d faults=%0d",
                 n, t.virt, t.phys, t.kind, beats, first_dv, faults);
    endtask

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L2 = 128'h04040404_03030303_02020202_01010101;
    localparam logic [127:0] L3 = 128'h40404040_30303030_20202020_10101010;
    localparam logic [127:0] L4 = 128'h14141414_0F0F0F0F_0A0A0A0A_05050505;
    localparam logic [127:0] L5 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] L6 = 128'h28000004_1E000003_14000002_0A000001;
    localparam logic [127:0] L7 = 128'h88888888_66666666_44444444_22222222;

    initial begin
        // virt, phys, tlb_hit, pcd, kind, beat0, expected line, gap, hold, flush_beat, rst_beat
        tv[0]  = mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_MISS,  32'h1111_1111, L1,     0, 0, 0, 0);
        tv[1]  = mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_HIT,   32'h0,         L1,     0, 0, 0, 0);
        tv[2]  = mk(32'h0000_2240, 32'h0007_7240, 1, 1, K_MISS,  32'h0101_0101, L2,     1, 0, 0, 0);
        tv[3]  = mk(32'h0000_2240, 32'h0007_7240, 1, 1, K_MISS,  32'h1010_1010, L3,     0, 0, 0, 0);
        tv[4]  = mk(32'h0000_3000, 32'h0000_3000, 0, 0, K_FAULT, 32'h0,         128'h0, 0, 0, 0, 0);
        tv[5]  = mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_HIT,   32'h0,         L1,     0, 0, 0, 0);
        tv[6]  = mk(32'h0000_1230, 32'h0009_9230, 1, 0, K_MISS,  32'h0505_0505, L4,     0, 6, 0, 0);
        tv[7]  = mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_MISS,  32'h1111_1111, L1,     0, 0, 0, 0);
        tv[8]  = mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_HIT,   32'h0,         L1,     0, 0, 0, 0);
        tv[9]  = mk(32'h0000_0000, 32'h0000_0000, 1, 0, K_MISS,  32'h0000_0001, L5,     0, 0, 0, 0);
        tv[10] = mk(32'h0000_1250, 32'h0004_5250, 1, 0, K_MISS,  32'h0A00_0001, L6,     0, 0, 2, 0);
        tv[11] = mk(32'h0000_1250, 32'h0004_5250, 1, 0, K_MISS,  32'h0A00_0001, L6,     0, 0, 0, 0);
        tv[12] = mk(32'h0000_1250, 32'h0004_5250, 1, 0, K_HIT,   32'h0,         L6,     0, 0, 0, 0);
        tv[13] = mk(32'h0000_1270, 32'h0004_5270, 1, 0, K_RST,   32'h2222_2222, L7,     0, 0, 0, 2);
        tv[14] = mk(32'h0000_1270, 32'h0004_5270, 1, 0, K_MISS,  32'h2222_2222, L7,     0, 0, 0, 0);
        tv[15] = mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_MISS,  32'h1111_1111, L1,     0, 0, 0, 0);

        reset = 1'b1; req_valid = 1'b0; req_address = '0; dp_ready = 1'b0; flush = 1'b0;
        phys_addr = '0; tlb_hit = 1'b0; tlb_pcd = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
        grant_in = 1'b1; bus_busy_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_dp_valid", dp_valid, 1'b0);
        chk("reset_page_fault", page_fault, 1'b0);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_bus_busy_out", bus_busy_out, 1'b0);
        chk("reset_mem_en", mem_en, 1'b0);
        chk("reset_dp_read_data", dp_read_data, 128'h0);
        chk("reset_grant_out_hi", grant_out, 1'b1);
        grant_in = 1'b0;
        #1;
        chk("reset_grant_out_lo", grant_out, 1'b0);
        grant_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", req_ready, 1'b1);
        chk("idle_grant_out", grant_out, 1'b1);

        for (int i = 0; i < NTV; i++) begin
            do_txn(i, tv[i]);
        end

        // Flush pulsed in IDLE: blocks the request port for that cycle and drops set 3.
        cur_txn = NTV;
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_req_ready_lo", req_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_req_ready_hi", req_ready, 1'b1);
        do_txn(NTV, mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_MISS, 32'h1111_1111, L1, 0, 0, 0, 0));
        do_txn(NTV + 1, mk(32'h0000_1230, 32'h0004_5230, 1, 0, K_HIT, 32'h0, L1, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
